fetch_stage: RTL



---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_stage_if.sv | 21 ++
 rtl/fetch_skid_buf.sv | 46 ++++
 rtl/fetch_stage.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSN_DEF = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    DROP = 3'd3,
    HOLD = 3'd4
  } fetch_state_e;

  // Fetch addresses are always word aligned; the low two bits are forced to zero.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and memory.
interface fetch_stage_if;
  import fetch_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_rvalid, imem_rdata
  );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry {ir, npc} buffer that parks a response arriving while decode is stalled.
module fetch_skid_buf
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSN = NOP_INSN_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            unload,
  input  logic            clear,
  input  logic [XLEN-1:0] load_ir,
  input  logic [XLEN-1:0] load_npc,
  output logic            full,
  output logic [XLEN-1:0] ir,
  output logic [XLEN-1:0] npc
);

  logic            full_r;
  logic [XLEN-1:0] ir_r;
  logic [XLEN-1:0] npc_r;

  // Occupancy and payload; clear wins over load so a redirect always empties it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_r <= 1'b0;
      ir_r   <= NOP_INSN;
      npc_r  <= 32'h0000_0000;
    end else if (clear) begin
      full_r <= 1'b0;
    end else if (load) begin
      full_r <= 1'b1;
      ir_r   <= load_ir;
      npc_r  <= load_npc;
    end else if (unload) begin
      full_r <= 1'b0;
    end else begin
      full_r <= full_r;
    end
  end

  assign full = full_r;
  assign ir   = ir_r;
  assign npc  = npc_r;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding fetches and drives IF/ID.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSN = NOP_INSN_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            hazard,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  fetch_stage_if.master   imem,
  output logic [XLEN-1:0] if_id_ir,
  output logic [XLEN-1:0] if_id_npc,
  output logic            if_id_valid
);

  fetch_state_e    state_r;
  logic [XLEN-1:0] pc_r;
  logic            req_r;
  logic [XLEN-1:0] ir_r;
  logic [XLEN-1:0] npc_r;
  logic            valid_r;

  logic            accept_s;
  logic [XLEN-1:0] pc_inc_s;
  logic            skid_load_s;
  logic            skid_unload_s;
  logic            skid_full_s;
  logic [XLEN-1:0] skid_ir_s;
  logic [XLEN-1:0] skid_npc_s;

  assign accept_s = req_r & imem.imem_ready;
  assign pc_inc_s = pc_r + 32'd4;

  // Skid is only touched when no redirect is pending.
  always_comb begin
    skid_load_s   = 1'b0;
    skid_unload_s = 1'b0;
    if (!redirect_valid) begin
      skid_load_s   = (state_r == WAIT) && imem.imem_rvalid && hazard;
      skid_unload_s = (state_r == HOLD) && skid_full_s && !hazard;
    end else begin
      skid_load_s   = 1'b0;
      skid_unload_s = 1'b0;
    end
  end

  fetch_skid_buf #(.NOP_INSN(NOP_INSN)) u_skid (
    .clk      (clk),
    .reset    (reset),
    .load     (skid_load_s),
    .unload   (skid_unload_s),
    .clear    (redirect_valid),
    .load_ir  (imem.imem_rdata),
    .load_npc (pc_inc_s),
    .full     (skid_full_s),
    .ir       (skid_ir_s),
    .npc      (skid_npc_s)
  );

  // Fetch FSM with PC, request and IF/ID registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      pc_r    <= RESET_PC;
      req_r   <= 1'b0;
      ir_r    <= NOP_INSN;
      npc_r   <= 32'h0000_0000;
      valid_r <= 1'b0;
    end else if (redirect_valid) begin
      // A request already accepted (or still in flight) must have its response swallowed in DROP.
      pc_r    <= align_word(redirect_pc);
      ir_r    <= NOP_INSN;
      npc_r   <= 32'h0000_0000;
      valid_r <= 1'b0;
      case (state_r)
        REQ: begin
          state_r <= accept_s ? DROP : REQ;
          req_r   <= !accept_s;
        end
        WAIT, DROP: begin
          state_r <= imem.imem_rvalid ? REQ : DROP;
          req_r   <= imem.imem_rvalid;
        end
        default: begin
          state_r <= REQ;
          req_r   <= 1'b1;
        end
      endcase
    end else begin
      if (hazard) begin
        ir_r    <= ir_r;
        npc_r   <= npc_r;
        valid_r <= valid_r;
      end else if ((state_r == WAIT) && imem.imem_rvalid) begin
        ir_r    <= imem.imem_rdata;
        npc_r   <= pc_inc_s;
        valid_r <= 1'b1;
      end else if (state_r == HOLD) begin
        ir_r    <= skid_ir_s;
        npc_r   <= skid_npc_s;
        valid_r <= 1'b1;
      end else begin
        ir_r    <= NOP_INSN;
        npc_r   <= 32'h0000_0000;
        valid_r <= 1'b0;
      end

      case (state_r)
        IDLE: begin
          state_r <= REQ;
          req_r   <= 1'b1;
        end
        REQ: begin
          state_r <= accept_s ? WAIT : REQ;
          req_r   <= !accept_s;
        end
        WAIT: begin
          if (imem.imem_rvalid) begin
            pc_r    <= pc_inc_s;
            state_r <= hazard ? HOLD : REQ;
            req_r   <= !hazard;
          end else begin
            state_r <= WAIT;
            req_r   <= 1'b0;
          end
        end
        DROP: begin
          state_r <= imem.imem_rvalid ? REQ : DROP;
          req_r   <= imem.imem_rvalid;
        end
        HOLD: begin
          state_r <= hazard ? HOLD : REQ;
          req_r   <= !hazard;
        end
        default: begin
          state_r <= IDLE;
          req_r   <= 1'b0;
        end
      endcase
    end
  end

  assign imem.imem_req  = req_r;
  assign imem.imem_addr = pc_r;
  assign if_id_ir       = ir_r;
  assign if_id_npc      = npc_r;
  assign if_id_valid    = valid_r;

endmodule
